alu_result_fifo: RTL and testbench
==================================

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface — parameters
REQ-001 SHALL have parameter WIDTH, default 32: result width in bits; must match the 32-bit bitwise/arith units feeding it.
REQ-002 SHALL have parameter DEPTH, default 4: number of entries; power of two, minimum 2.

Interface — ports
REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1: synchronous discard of all stored entries.
REQ-006 SHALL have port in_valid  input  1: producer presents a result this cycle.
REQ-007 SHALL have port in_ready  output  1: buffer can accept a result this cycle.
REQ-008 SHALL have port in_result  input  WIDTH: result word from the XOR/AND/ADD stage.
REQ-009 SHALL have port in_carryout  input  1: carry flag accompanying in_result.
REQ-010 SHALL have port in_overflow  input  1: overflow flag accompanying in_result.
REQ-011 SHALL have port out_valid  output  1: head entry is valid.
REQ-012 SHALL have port out_ready  input  1: consumer accepts head entry this cycle.
REQ-013 SHALL have port out_result  output  WIDTH: head result word.
REQ-014 SHALL have port out_zero  output  1: head result equals zero.
REQ-015 SHALL have port out_carryout  output  1: head carry flag.
REQ-016 SHALL have port out_overflow  output  1: head overflow flag.
REQ-017 SHALL have port count  output  clog2(DEPTH)+1: number of stored entries.

Function
REQ-018 SHALL push when in_valid && in_ready at a rising edge; pop when out_valid && out_ready.
REQ-019 SHALL drive in_ready = (count < DEPTH), combinationally from registered count only; no dependence on out_ready.
REQ-020 SHALL drive out_valid = (count != 0); out_* fields SHALL reflect the head entry, directly from storage.
REQ-021 SHALL compute the zero flag at push time as (in_result == 0) and store it with the entry.
REQ-022 SHALL have latency exactly 1 cycle: a word pushed at edge N is visible on out_* with out_valid=1 after edge N; no combinational in->out bypass.
REQ-023 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-024 SHALL, when full, ignore in_valid (no push) even if a pop occurs in the same cycle.
REQ-025 SHALL, when empty, ignore out_ready (no pop, pointers unchanged).
REQ-026 SHALL wrap read/write pointers modulo DEPTH.
REQ-027 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-028 SHALL, on flush=1, set count and both pointers to 0 at the edge; flush overrides any push/pop in that cycle.
REQ-029 SHALL preserve entry order strictly (FIFO); flags never separate from their result.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force count=0, pointers=0, out_valid=0, in_ready=1.
REQ-031 SHALL drive out_result, out_zero, out_carryout, out_overflow to 0 while empty, including after reset.
REQ-032 SHALL, on reset assertion mid-transfer, discard all entries; the first edge after rst_n rises performs normal push/pop.

Verification
REQ-033 SHALL cover: reset release, push in_result=32'hA5A5_5A5A carry=1 -> next cycle out_valid=1, out_result=A5A55A5A, out_zero=0, out_carryout=1, count=1.
REQ-034 SHALL cover: push 0x00000000 -> out_zero=1; push 0xFFFFFFFF behind it -> popped second with out_zero=0.
REQ-035 SHALL cover: 4 pushes with out_ready=0 -> count=4, in_ready=0; 5th in_valid with out_ready=1 -> pop only, count=3, 5th word absent.
REQ-036 SHALL cover: steady push+pop every cycle for 10 words across pointer wrap -> count constant, output order equals input order.
REQ-037 SHALL cover: count=3, flush=1 with in_valid=1 -> count=0, out_valid=0, all out_* fields 0, pushed word dropped.
REQ-038 SHALL cover: rst_n pulsed low between clock edges with count=2 -> out_valid=0 and count=0 immediately, before next edge.

Source files
------------

// File: rtl/alu_result_fifo_if.sv
// Handshake bundle between an ALU result producer, the result FIFO and its consumer.
interface alu_result_fifo_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_carryout;
  logic             in_overflow;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_carryout;
  logic             out_overflow;

  // FIFO-side view
  modport slave (
    input  in_valid, in_result, in_carryout, in_overflow, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_carryout, out_overflow
  );

  // Environment-side view (producer and consumer together)
  modport master (
    output in_valid, in_result, in_carryout, in_overflow, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_carryout, out_overflow
  );
endinterface

// File: rtl/alu_result_fifo.sv
// Small FIFO buffering ALU results with their carry/overflow flags and a
// zero flag computed on entry. One cycle push-to-visible latency, no bypass.
module alu_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  alu_result_fifo_if.slave        bus,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = WIDTH + 3;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  // Entry layout: {result, zero, carry, overflow}; the zero flag is fixed at push time.
  function automatic logic [EW-1:0] pack_entry(input logic [WIDTH-1:0] res,
                                               input logic carry,
                                               input logic ovf);
    return {res, (res == {WIDTH{1'b0}}), carry, ovf};
  endfunction

  // Readiness depends on registered occupancy only, never on the consumer.
  assign bus.in_ready  = (count < FULL_COUNT);
  assign bus.out_valid = (count != {(AW+1){1'b0}});
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;
  assign head          = mem[rd_ptr];

  // Present the head entry, or all-zero fields when nothing is stored.
  always_comb begin
    bus.out_result   = {WIDTH{1'b0}};
    bus.out_zero     = 1'b0;
    bus.out_carryout = 1'b0;
    bus.out_overflow = 1'b0;
    if (bus.out_valid) begin
      bus.out_result   = head[EW-1:3];
      bus.out_zero     = head[2];
      bus.out_carryout = head[1];
      bus.out_overflow = head[0];
    end else begin
      bus.out_result   = {WIDTH{1'b0}};
      bus.out_zero     = 1'b0;
      bus.out_carryout = 1'b0;
      bus.out_overflow = 1'b0;
    end
  end

  // Pointer and occupancy bookkeeping; flush wins over any push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {(AW+1){1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end else begin
        rd_ptr <= rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset because empty outputs are masked.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= pack_entry(bus.in_result, bus.in_carryout, bus.in_overflow);
    end
  end
endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_alu_result_fifo;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [2:0] count;

  alu_result_fifo_if #(.WIDTH(32)) bus ();

  alu_result_fifo #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        o;
  } entry_t;

  typedef struct {
    logic        v;
    logic        r;
    logic [31:0] d;
    logic        c;
    logic        o;
    int          e_cnt;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_res;
    logic        e_z;
    logic        e_c;
    logic        e_o;
  } vec_t;

  entry_t model[$];
  vec_t   vecs[$];
  int     n_checks;
  int     n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the reference model's view of the queue.
  task automatic check_model(input string tag);
    entry_t h;
    logic   nonempty;
    nonempty = (model.size() != 0);
    if (nonempty) h = model[0];
    else h = '{res: 32'h0, c: 1'b0, o: 1'b0};
    chk({tag, ".count"},     32'(count),              32'(model.size()));
    chk({tag, ".in_ready"},  32'(bus.in_ready),       32'(model.size() < DEPTH));
    chk({tag, ".out_valid"}, 32'(bus.out_valid),      32'(nonempty));
    chk({tag, ".out_result"}, bus.out_result,         h.res);
    chk({tag, ".out_zero"},  32'(bus.out_zero),       32'(nonempty && h.res == 32'h0));
    chk({tag, ".out_carry"}, 32'(bus.out_carryout),   32'(h.c));
    chk({tag, ".out_ovf"},   32'(bus.out_overflow),   32'(h.o));
  endtask

  // Drive one cycle of inputs, clock it, and advance the reference model.
  task automatic step(input logic v, input logic r, input logic f,
                      input logic [31:0] d, input logic c, input logic o);
    bit do_push;
    bit do_pop;
    bus.in_valid    = v;
    bus.out_ready   = r;
    flush           = f;
    bus.in_result   = d;
    bus.in_carryout = c;
    bus.in_overflow = o;
    do_push = v && (model.size() < DEPTH);
    do_pop  = r && (model.size() > 0);
    @(posedge clk);
    if (f) begin
      model.delete();
    end else begin
      if (do_pop) void'(model.pop_front());
      if (do_push) model.push_back('{res: d, c: c, o: o});
    end
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    bus.in_result   = 32'h0;
    bus.in_carryout = 1'b0;
    bus.in_overflow = 1'b0;

    // Reset state
    #12;
    check_model("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table: first push, zero flag ordering, full-with-pop, drain.
    vecs.push_back('{1'b1, 1'b0, 32'hA5A5_5A5A, 1'b1, 1'b0, 1, 1'b1, 1'b1, 32'hA5A5_5A5A, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0011, 1'b0, 1'b0, 1, 1'b1, 1'b1, 32'h0000_0011, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0022, 1'b1, 1'b0, 2, 1'b1, 1'b1, 32'h0000_0011, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0033, 1'b0, 1'b1, 3, 1'b1, 1'b1, 32'h0000_0011, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0044, 1'b1, 1'b1, 4, 1'b0, 1'b1, 32'h0000_0011, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'h0000_0055, 1'b1, 1'b1, 3, 1'b1, 1'b1, 32'h0000_0022, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 2, 1'b1, 1'b1, 32'h0000_0033, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1, 1'b1, 1'b1, 32'h0000_0044, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0});

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].r, 1'b0, vecs[i].d, vecs[i].c, vecs[i].o);
      chk($sformatf("vec%0d.count", i),     32'(count),            32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d.in_ready", i),  32'(bus.in_ready),     32'(vecs[i].e_ir));
      chk($sformatf("vec%0d.out_valid", i), 32'(bus.out_valid),    32'(vecs[i].e_ov));
      chk($sformatf("vec%0d.out_result", i), bus.out_result,       vecs[i].e_res);
      chk($sformatf("vec%0d.out_zero", i),  32'(bus.out_zero),     32'(vecs[i].e_z));
      chk($sformatf("vec%0d.out_carry", i), 32'(bus.out_carryout), 32'(vecs[i].e_c));
      chk($sformatf("vec%0d.out_ovf", i),   32'(bus.out_overflow), 32'(vecs[i].e_o));
    end

    // Steady push+pop across pointer wrap: occupancy constant, order kept.
    step(1'b1, 1'b0, 1'b0, 32'h1000_0000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h1000_0001 + 32'(i), 1'(i), 1'(i >> 1));
      chk($sformatf("wrap%0d.count", i), 32'(count), 32'd1);
      chk($sformatf("wrap%0d.head", i), bus.out_result, 32'h1000_0001 + 32'(i));
      check_model($sformatf("wrap%0d", i));
    end
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    check_model("wrap_drain");

    // Flush with three entries and a simultaneous push.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'hC0DE_0000 + 32'(i), 1'b1, 1'b1);
    chk("preflush.count", 32'(count), 32'd3);
    step(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    chk("flush.count", 32'(count), 32'd0);
    chk("flush.out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush.out_result", bus.out_result, 32'h0);
    check_model("flush");
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_model("postflush");

    // Asynchronous reset between edges with two entries stored.
    step(1'b1, 1'b0, 1'b0, 32'h0000_0AAA, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0000_0BBB, 1'b0, 1'b0);
    chk("prerst.count", 32'(count), 32'd2);
    bus.in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("asyncrst.count", 32'(count), 32'd0);
    chk("asyncrst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("asyncrst.in_ready", 32'(bus.in_ready), 32'd1);
    model.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 32'h0000_0CCC, 1'b1, 1'b0);
    check_model("postrst_push");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 40) == 0), d, 1'($urandom), 1'($urandom));
      check_model($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
